fs_dither_stream: RTL and testbench
===================================

// Module: fs_dither_stream
// PURPOSE
//  Streaming Floyd-Steinberg error-diffusion engine: one pixel/cycle in raster order, quantised pixel out.
//  Replaces SRAM read-modify-write diffusion with internal ping-pong row error buffers; no clear pass.
//  Generalised in image size, input depth and output depth; runtime bypass (plain threshold) mode.
//  Sits between the image loader (s_*) and the output frame store (m_*).
// PARAMETERS
//  IMG_W   64   pixels per row (>=2)
//  IMG_H   64   rows per frame (>=1)
//  PIX_W   8    input pixel width, unsigned
//  OUT_W   1    output pixel width (1 = black/white); 1 <= OUT_W <= PIX_W
//  ERR_W   PIX_W+6  signed width of scaled (x16) error accumulators
// PORTS
//  clk        in   1      clock
//  rst        in   1      asynchronous, active-high reset
//  dither_en  in   1      1 = diffuse error, 0 = plain quantise; sampled on (0,0) accept
//  s_valid    in   1      input pixel valid
//  s_ready    out  1      input ready
//  s_data     in   PIX_W  input pixel
//  s_sof      in   1      marks first pixel of frame
//  m_valid    out  1      output pixel valid
//  m_ready    in   1      downstream ready
//  m_data     out  OUT_W  quantised pixel
//  m_sof/m_eol/m_eof out 1  flags: pixel (0,0) / x==IMG_W-1 / last pixel of frame
//  frame_done out  1      1-cycle pulse when m_eof beat handshakes
//  sync_err   out  1      sticky: s_sof seen away from (0,0); cleared by rst only
// BEHAVIOUR
//  Reset: all outputs 0; x=y=0; dither mode=1; buffer contents don't-care (never read before written).
//  Handshake: accept when s_valid&&s_ready; s_ready = !m_valid || m_ready. Result registered: pixel
//   accepted in cycle N is on m_* from N+1, held stable until m_valid&&m_ready. Throughput 1/cycle.
//  Counters: x++ per accept; x==IMG_W-1 -> x=0,y++; last pixel -> x=y=0. Flags from counters, not s_sof.
//  Arithmetic per pixel (x,y), e_prev = error of (x-1,y), 0 when x==0:
//   total = (s_data<<4) + R[x] + 7*e_prev ; R[x] = cur-row acc, forced 0 when y==0
//   v = clamp(total >>> 4, 0, 2^PIX_W-1) (arithmetic shift = floor)
//   q = v >> (PIX_W-OUT_W); recon = q bit-replicated to PIX_W (OUT_W=1: 0/255)
//   e = v - recon, signed PIX_W+1 bits; m_data = q.
//  Next-row acc N: N[x-1]+=3e (x>0); N[x]+=5e; N[x+1]=1e written, not added (x<IMG_W-1) -> initialises.
//   Edge error (x==0 SW, x==IMG_W-1 E/SE) dropped. On last row N updates suppressed.
//  Row end: N becomes R (ping-pong select toggles), zero extra cycles.
//  Bypass (mode 0): e forced 0 in all terms; m_data = s_data >> (PIX_W-OUT_W).
//  s_sof=1 accepted at (x,y)!=(0,0): sync_err<=1, pixel treated as (0,0) (y==0 rules, mode resampled).
//   (0,0) accepted without s_sof: normal, no error.
//  Stall: no accept -> counters, e_prev, buffers frozen; no pixel dropped or duplicated.
//  rst mid-frame: immediate clear as above; in-flight output discarded; next accept is (0,0).
// TESTING (IMG_W=4, IMG_H=2, PIX_W=8, OUT_W=1 unless noted)
//  1 Frame all 96, dither_en=1 -> (0,0) out 0 (e=96); (1,0) total=2208, v=138 -> out 1, e=-117.
//  2 dither_en=0, pixels 127,128,0,255 -> 0,1,0,1; no diffusion on row 1 (same inputs -> same outputs).
//  3 m_ready low 5 cycles mid-row -> s_ready low, m_data stable; output stream matches no-stall run.
//  4 s_sof at (2,0) -> sync_err=1 sticky, that beat m_sof=1, frame of 8 beats follows, m_eof on 8th.
//  5 rst after 3 pixels -> m_valid=0, flags 0; next full frame bit-exact vs golden C model.
//  6 OUT_W=2, all 170 -> every out 2 (recon 170, e=0); all 255 -> 3; random frames vs C model.

Source files
------------

// File: rtl/fs_dither_stream.sv
// Streaming Floyd-Steinberg error-diffusion quantiser. Accepts one pixel per cycle in raster
// order and emits one quantised pixel per cycle. The next-row error is kept in two row buffers
// that swap roles at every row end. The current-row error comes from a single carried register.
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   i_dither_en     1 = diffuse error, 0 = plain threshold; sampled when pixel (0,0) is accepted
//   i_s_valid/o_s_ready/i_s_data/i_s_sof   input pixel stream
//   o_m_valid/i_m_ready/o_m_data           quantised output stream
//   o_m_sof/o_m_eol/o_m_eof                position flags of the output beat
//   o_frame_done    1-cycle pulse in the cycle after the m_eof beat handshakes
//   o_sync_err      sticky: s_sof seen on a beat that was not at (0,0)
module fs_dither_stream #(
   parameter int IMG_W = 64,
   parameter int IMG_H = 64,
   parameter int PIX_W = 8,
   parameter int OUT_W = 1,
   parameter int ERR_W = PIX_W + 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_dither_en,
   input  logic             i_s_valid,
   output logic             o_s_ready,
   input  logic [PIX_W-1:0] i_s_data,
   input  logic             i_s_sof,
   output logic             o_m_valid,
   input  logic             i_m_ready,
   output logic [OUT_W-1:0] o_m_data,
   output logic             o_m_sof,
   output logic             o_m_eol,
   output logic             o_m_eof,
   output logic             o_frame_done,
   output logic             o_sync_err
);

   localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int TW = ERR_W + 2;
   localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
   localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
   localparam logic signed [TW-1:0] V_MAX = TW'((2 ** PIX_W) - 1);

   // Position, mode and error state
   logic [XW-1:0]            r_x;
   logic [YW-1:0]            r_y;
   logic                     r_mode;
   logic                     r_sel;
   logic signed [PIX_W:0]    r_eprev;
   logic signed [ERR_W-1:0]  r_buf [2][IMG_W];

   // Output registers
   logic                     r_m_valid;
   logic [OUT_W-1:0]         r_m_data;
   logic                     r_m_sof;
   logic                     r_m_eol;
   logic                     r_m_eof;
   logic                     r_frame_done;
   logic                     r_sync_err;

   logic                     w_accept;
   logic                     w_resync;
   logic [XW-1:0]            w_x;
   logic [YW-1:0]            w_y;
   logic [XW-1:0]            w_xm1;
   logic [XW-1:0]            w_xp1;
   logic                     w_first;
   logic                     w_mode;
   logic                     w_col_last;
   logic                     w_row_last;
   logic                     w_nsel;
   logic signed [ERR_W-1:0]  w_r_acc;
   logic signed [PIX_W:0]    w_ep;
   logic signed [TW-1:0]     w_pix_s;
   logic signed [TW-1:0]     w_r_s;
   logic signed [TW-1:0]     w_ep_s;
   logic signed [TW-1:0]     w_total;
   logic signed [TW-1:0]     w_shift;
   logic [PIX_W-1:0]         w_v;
   logic [OUT_W-1:0]         w_q;
   logic [PIX_W-1:0]         w_recon;
   logic signed [PIX_W:0]    w_e;
   logic signed [ERR_W-1:0]  w_e_s;
   logic signed [ERR_W-1:0]  w_e3;
   logic signed [ERR_W-1:0]  w_e5;

   assign o_s_ready = !r_m_valid || i_m_ready;
   assign w_accept  = i_s_valid && o_s_ready;

   // A misplaced s_sof restarts the frame: the beat is processed as pixel (0,0)
   assign w_resync   = i_s_sof && ((r_x != '0) || (r_y != '0));
   assign w_x        = w_resync ? '0 : r_x;
   assign w_y        = w_resync ? '0 : r_y;
   assign w_xm1      = w_x - 1'b1;
   assign w_xp1      = w_x + 1'b1;
   assign w_first    = (w_x == '0) && (w_y == '0);
   assign w_mode     = w_first ? i_dither_en : r_mode;
   assign w_col_last = (w_x == X_LAST);
   assign w_row_last = (w_y == Y_LAST);
   assign w_nsel     = ~r_sel;

   // Row 0 never reads the buffer, so stale contents from a previous frame are harmless
   assign w_r_acc = (w_y == '0) ? '0 : r_buf[r_sel][w_x];
   assign w_ep    = (w_x == '0) ? '0 : r_eprev;

   assign w_pix_s = signed'(TW'({i_s_data, 4'b0000}));
   assign w_r_s   = TW'(w_r_acc);
   assign w_ep_s  = TW'(w_ep);
   assign w_total = w_pix_s + w_r_s + (w_ep_s <<< 3) - w_ep_s;
   assign w_shift = w_total >>> 4;

   always_comb begin
      if (w_shift[TW-1]) begin
         w_v = '0;
      end else if (w_shift > V_MAX) begin
         w_v = '1;
      end else begin
         w_v = w_shift[PIX_W-1:0];
      end
   end

   assign w_q = w_mode ? w_v[PIX_W-1 -: OUT_W] : i_s_data[PIX_W-1 -: OUT_W];

   // Replicate q from the MSB down to rebuild the full-scale level it represents
   always_comb begin
      w_recon = '0;
      for (int i = 0; i < PIX_W; i++) begin
         w_recon[i] = w_q[OUT_W - 1 - ((PIX_W - 1 - i) % OUT_W)];
      end
   end

   assign w_e   = w_mode ? (signed'({1'b0, w_v}) - signed'({1'b0, w_recon})) : '0;
   assign w_e_s = ERR_W'(w_e);
   assign w_e3  = w_e_s + (w_e_s <<< 1);
   assign w_e5  = w_e_s + (w_e_s <<< 2);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_x          <= '0;
         r_y          <= '0;
         r_mode       <= 1'b1;
         r_sel        <= 1'b0;
         r_eprev      <= '0;
         r_m_valid    <= 1'b0;
         r_m_data     <= '0;
         r_m_sof      <= 1'b0;
         r_m_eol      <= 1'b0;
         r_m_eof      <= 1'b0;
         r_frame_done <= 1'b0;
         r_sync_err   <= 1'b0;
      end else begin
         r_frame_done <= r_m_valid && i_m_ready && r_m_eof;
         if (w_accept) begin
            r_mode    <= w_mode;
            r_eprev   <= w_e;
            r_m_valid <= 1'b1;
            r_m_data  <= w_q;
            r_m_sof   <= w_first;
            r_m_eol   <= w_col_last;
            r_m_eof   <= w_col_last && w_row_last;
            if (w_resync) begin
               r_sync_err <= 1'b1;
            end
            if (w_col_last) begin
               r_x   <= '0;
               r_y   <= w_row_last ? '0 : w_y + 1'b1;
               r_sel <= ~r_sel;
            end else begin
               r_x <= w_x + 1'b1;
               r_y <= w_y;
            end
         end else if (i_m_ready) begin
            r_m_valid <= 1'b0;
         end
      end
   end

   // Next-row accumulation. The SE tap writes rather than adds, and x==0 writes its S tap,
   // so every entry is initialised during the row before it is read.
   always_ff @(posedge clk) begin
      if (w_accept && !w_row_last) begin
         if (w_x != '0) begin
            r_buf[w_nsel][w_xm1] <= r_buf[w_nsel][w_xm1] + w_e3;
            r_buf[w_nsel][w_x]   <= r_buf[w_nsel][w_x] + w_e5;
         end else begin
            r_buf[w_nsel][w_x] <= w_e5;
         end
         if (!w_col_last) begin
            r_buf[w_nsel][w_xp1] <= w_e_s;
         end
      end
   end

   assign o_m_valid    = r_m_valid;
   assign o_m_data     = r_m_data;
   assign o_m_sof      = r_m_sof;
   assign o_m_eol      = r_m_eol;
   assign o_m_eof      = r_m_eof;
   assign o_frame_done = r_frame_done;
   assign o_sync_err   = r_sync_err;

endmodule

// File: tb/tb_fs_dither_stream.sv
// Bench for fs_dither_stream: a 4x2 frame instance with 1-bit output and one with 2-bit output
// share all inputs. A frame-level Floyd-Steinberg model predicts every output beat.
module tb_fs_dither_stream;

   localparam int W = 4;
   localparam int H = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       den = 1'b1;
   logic       sv = 1'b0;
   logic       ssof = 1'b0;
   logic       mr = 1'b1;
   logic [7:0] sd = 8'd0;

   logic       rdy1, mv1, sof1, eol1, eof1, fd1, se1;
   logic [0:0] md1;
   logic       rdy2, mv2, sof2, eol2, eof2, fd2, se2;
   logic [1:0] md2;

   always #5 clk = ~clk;

   fs_dither_stream #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .OUT_W(1)) u_dut1 (
      .clk(clk), .rst(rst), .i_dither_en(den), .i_s_valid(sv), .o_s_ready(rdy1),
      .i_s_data(sd), .i_s_sof(ssof), .o_m_valid(mv1), .i_m_ready(mr), .o_m_data(md1),
      .o_m_sof(sof1), .o_m_eol(eol1), .o_m_eof(eof1), .o_frame_done(fd1), .o_sync_err(se1)
   );

   fs_dither_stream #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .OUT_W(2)) u_dut2 (
      .clk(clk), .rst(rst), .i_dither_en(den), .i_s_valid(sv), .o_s_ready(rdy2),
      .i_s_data(sd), .i_s_sof(ssof), .o_m_valid(mv2), .i_m_ready(mr), .o_m_data(md2),
      .o_m_sof(sof2), .o_m_eol(eol2), .o_m_eof(eof2), .o_frame_done(fd2), .o_sync_err(se2)
   );

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: position, mode and x16 error accumulators for the whole frame
   int mx = 0;
   int my = 0;
   int mmode = 1;
   int macc [2][H][W];
   logic [8:0] expq [$];

   logic       t_acc, t_hs;
   logic [1:0] t_rdy;
   logic [8:0] t_obs;
   logic [8:0] e9;

   // k=0: 1-bit output, k=1: 2-bit output
   function automatic int mquant(input int k, input int pix);
      int total, v, q, recon, e;
      total = pix * 16 + macc[k][my][mx];
      v = total >>> 4;
      if (v < 0) v = 0;
      if (v > 255) v = 255;
      q = v >> (7 - k);
      recon = (k == 0) ? q * 255 : q * 85;
      e = (mmode != 0) ? v - recon : 0;
      if (mx + 1 < W) macc[k][my][mx+1] += 7 * e;
      if (my + 1 < H) begin
         if (mx > 0) macc[k][my+1][mx-1] += 3 * e;
         macc[k][my+1][mx] += 5 * e;
         if (mx + 1 < W) macc[k][my+1][mx+1] += e;
      end
      return q;
   endfunction

   task automatic model_accept(input int pix, input logic sof, input logic d);
      int q1, q2;
      logic fs, fe, ff;
      if (sof && (mx != 0 || my != 0)) begin
         mx = 0;
         my = 0;
      end
      if (mx == 0 && my == 0) begin
         mmode = int'(d);
         for (int k = 0; k < 2; k++)
            for (int yy = 0; yy < H; yy++)
               for (int xx = 0; xx < W; xx++) macc[k][yy][xx] = 0;
      end
      fs = (mx == 0 && my == 0);
      fe = (mx == W - 1);
      ff = fe && (my == H - 1);
      q1 = mquant(0, pix);
      q2 = mquant(1, pix);
      expq.push_back({q1[0], fs, fe, ff, q2[1:0], fs, fe, ff});
      if (fe) begin
         mx = 0;
         my = (my == H - 1) ? 0 : my + 1;
      end else begin
         mx = mx + 1;
      end
   endtask

   task automatic model_reset();
      mx = 0;
      my = 0;
      mmode = 1;
      expq.delete();
   endtask

   // One clock: drive at the falling edge, capture handshakes, return at the next falling edge
   task automatic tick(input logic v, input logic [7:0] d, input logic sof, input logic r,
                       input logic de);
      sv = v;
      sd = d;
      ssof = sof;
      mr = r;
      den = de;
      #1;
      t_rdy = {rdy1, rdy2};
      t_acc = v && rdy1;
      t_hs  = mv1 && r;
      t_obs = {md1, sof1, eol1, eof1, md2, sof2, eol2, eof2};
      if (t_acc) model_accept(int'(d), sof, de);
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      #2;
      n_checks++;
      if ({mv1, mv2, sof1, eol1, eof1, sof2, eol2, eof2, fd1, fd2, se1, se2, md1, md2} !== '0) begin
         n_errors++;
         $display("FAIL reset_outputs: got %b want 0", {mv1, mv2, sof1, eol1, eof1, sof2, eol2,
                  eof2, fd1, fd2, se1, se2, md1, md2});
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({mv1, mv2, fd1, fd2, se1, se2} !== 6'b0) begin
         n_errors++;
         $display("FAIL reset_release: got %b want 000000", {mv1, mv2, fd1, fd2, se1, se2});
      end
      n_checks++;
      if ({rdy1, rdy2} !== 2'b11) begin
         n_errors++;
         $display("FAIL reset_ready: got %b want 11", {rdy1, rdy2});
      end
   endtask

   task automatic test_dither_basic();
      int sent = 0, got = 0;
      logic exp_fd;
      for (int c = 0; c < 40 && got < 8; c++) begin
         tick(sent < 8, 8'd96, sent == 0, 1'b1, 1'b1);
         if (t_acc) sent++;
         exp_fd = 1'b0;
         if (t_hs) begin
            got++;
            e9 = 'x;
            if (expq.size() > 0) e9 = expq.pop_front();
            exp_fd = e9[5];
            n_checks++;
            if (t_obs !== e9) begin
               n_errors++;
               $display("FAIL basic_beat%0d: got %b want %b", got, t_obs, e9);
            end
            if (got <= 2) begin
               n_checks++;
               if (t_obs[8] !== (got == 2)) begin
                  n_errors++;
                  $display("FAIL basic_px%0d_value: got %b want %b", got - 1, t_obs[8], got == 2);
               end
            end
         end
         n_checks++;
         if ({fd1, fd2} !== {exp_fd, exp_fd}) begin
            n_errors++;
            $display("FAIL frame_done: got %b want %b", {fd1, fd2}, {exp_fd, exp_fd});
         end
      end
      n_checks++;
      if (got != 8) begin
         n_errors++;
         $display("FAIL basic_timeout: got %0d beats want 8", got);
      end
   endtask

   task automatic test_bypass();
      int bp[4] = '{127, 128, 0, 255};
      int b1[4] = '{0, 1, 0, 1};
      int b2[4] = '{1, 2, 0, 3};
      int sent = 0, got = 0, k;
      logic [2:0] want;
      for (int c = 0; c < 40 && got < 8; c++) begin
         tick(sent < 8, 8'(bp[sent % 4]), sent == 0, 1'b1, 1'b0);
         if (t_acc) sent++;
         if (t_hs) begin
            k = got % 4;
            got++;
            e9 = 'x;
            if (expq.size() > 0) e9 = expq.pop_front();
            n_checks++;
            if (t_obs !== e9) begin
               n_errors++;
               $display("FAIL bypass_model_beat%0d: got %b want %b", got, t_obs, e9);
            end
            want = {1'(b1[k]), 2'(b2[k])};
            n_checks++;
            if ({t_obs[8], t_obs[4:3]} !== want) begin
               n_errors++;
               $display("FAIL bypass_beat%0d: got %b want %b", got, {t_obs[8], t_obs[4:3]}, want);
            end
         end
      end
      n_checks++;
      if (got != 8) begin
         n_errors++;
         $display("FAIL bypass_timeout: got %0d beats want 8", got);
      end
   endtask

   task automatic test_stall();
      logic [7:0] px[8];
      int sent = 0, got = 0, stall = 0;
      logic started = 1'b0;
      logic r;
      logic [8:0] held;
      for (int i = 0; i < 8; i++) px[i] = 8'($urandom_range(255));
      for (int c = 0; c < 60 && got < 8; c++) begin
         if (got == 2 && !started) begin
            stall = 5;
            started = 1'b1;
         end
         r = (stall == 0);
         tick(sent < 8, px[sent % 8], 1'b0, r, 1'b1);
         if (stall > 0) begin
            n_checks++;
            if (t_rdy !== 2'b00) begin
               n_errors++;
               $display("FAIL stall_ready: got %b want 00", t_rdy);
            end
            if (stall == 5) begin
               held = t_obs;
            end else begin
               n_checks++;
               if (t_obs !== held) begin
                  n_errors++;
                  $display("FAIL stall_hold: got %b want %b", t_obs, held);
               end
            end
            stall--;
         end
         if (t_acc) sent++;
         if (t_hs) begin
            got++;
            e9 = 'x;
            if (expq.size() > 0) e9 = expq.pop_front();
            n_checks++;
            if (t_obs !== e9) begin
               n_errors++;
               $display("FAIL stall_beat%0d: got %b want %b", got, t_obs, e9);
            end
         end
      end
      n_checks++;
      if (got != 8 || {se1, se2} !== 2'b00) begin
         n_errors++;
         $display("FAIL stall_end: got %0d beats sync_err %b want 8 beats 00", got, {se1, se2});
      end
   endtask

   task automatic test_sync();
      logic [7:0] px[18];
      int sent = 0, got = 0;
      logic sof;
      for (int i = 0; i < 18; i++) px[i] = 8'($urandom_range(255));
      for (int c = 0; c < 80 && got < 18; c++) begin
         sof = (sent == 0 || sent == 2 || sent == 10);
         tick(sent < 18, px[sent % 18], sof, 1'b1, 1'b1);
         if (t_acc) begin
            if (sent == 1 || sent == 2) begin
               n_checks++;
               if ({se1, se2} !== {2{sent == 2}}) begin
                  n_errors++;
                  $display("FAIL sync_err_beat%0d: got %b want %b", sent, {se1, se2},
                           {2{sent == 2}});
               end
            end
            sent++;
         end
         if (t_hs) begin
            got++;
            e9 = 'x;
            if (expq.size() > 0) e9 = expq.pop_front();
            n_checks++;
            if (t_obs !== e9) begin
               n_errors++;
               $display("FAIL sync_beat%0d: got %b want %b", got, t_obs, e9);
            end
            if (got == 3 || got == 10) begin
               n_checks++;
               if ({t_obs[7], t_obs[5]} !== ((got == 3) ? 2'b10 : 2'b01)) begin
                  n_errors++;
                  $display("FAIL sync_flags_beat%0d: got sof/eof %b", got, {t_obs[7], t_obs[5]});
               end
            end
         end
      end
      n_checks++;
      if (got != 18 || {se1, se2} !== 2'b11) begin
         n_errors++;
         $display("FAIL sync_sticky: got %0d beats sync_err %b want 18 beats 11", got, {se1, se2});
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] px[8];
      int sent = 0, got = 0;
      logic d;
      for (int c = 0; c < 3; c++) begin
         tick(1'b1, 8'($urandom_range(255)), c == 0, 1'b1, 1'b1);
         if (t_hs) begin
            e9 = 'x;
            if (expq.size() > 0) e9 = expq.pop_front();
            n_checks++;
            if (t_obs !== e9) begin
               n_errors++;
               $display("FAIL pre_reset_beat: got %b want %b", t_obs, e9);
            end
         end
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if ({mv1, mv2, sof1, eol1, eof1, sof2, eol2, eof2, fd1, fd2, se1, se2} !== 12'b0) begin
         n_errors++;
         $display("FAIL mid_reset_outputs: got %b want 0", {mv1, mv2, sof1, eol1, eof1, sof2,
                  eol2, eof2, fd1, fd2, se1, se2});
      end
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      d = 1'($urandom_range(1));
      for (int i = 0; i < 8; i++) px[i] = 8'($urandom_range(255));
      for (int c = 0; c < 80 && got < 8; c++) begin
         tick(sent < 8 && $urandom_range(3) != 0, px[sent % 8], 1'b0,
              $urandom_range(3) != 0, d);
         if (t_acc) sent++;
         if (t_hs) begin
            got++;
            e9 = 'x;
            if (expq.size() > 0) e9 = expq.pop_front();
            n_checks++;
            if (t_obs !== e9) begin
               n_errors++;
               $display("FAIL post_reset_beat%0d: got %b want %b", got, t_obs, e9);
            end
         end
      end
      n_checks++;
      if (got != 8) begin
         n_errors++;
         $display("FAIL post_reset_timeout: got %0d beats want 8", got);
      end
   endtask

   task automatic test_outw2();
      logic [7:0] px[8];
      int sent, got;
      logic d, rnd;
      for (int f = 0; f < 6; f++) begin
         sent = 0;
         got = 0;
         rnd = (f >= 2);
         d = rnd ? 1'($urandom_range(1)) : 1'b1;
         for (int i = 0; i < 8; i++)
            px[i] = (f == 0) ? 8'd170 : (f == 1) ? 8'd255 : 8'($urandom_range(255));
         for (int c = 0; c < 80 && got < 8; c++) begin
            tick(sent < 8 && (!rnd || $urandom_range(3) != 0), px[sent % 8],
                 sent == 0 && $urandom_range(1) == 1, !rnd || $urandom_range(3) != 0, d);
            if (t_acc) sent++;
            if (t_hs) begin
               got++;
               e9 = 'x;
               if (expq.size() > 0) e9 = expq.pop_front();
               n_checks++;
               if (t_obs !== e9) begin
                  n_errors++;
                  $display("FAIL outw_f%0d_beat%0d: got %b want %b", f, got, t_obs, e9);
               end
               if (!rnd) begin
                  n_checks++;
                  if (t_obs[4:3] !== ((f == 0) ? 2'd2 : 2'd3)) begin
                     n_errors++;
                     $display("FAIL outw2_const_f%0d: got %0d want %0d", f, t_obs[4:3],
                              (f == 0) ? 2 : 3);
                  end
               end
            end
         end
         n_checks++;
         if (got != 8) begin
            n_errors++;
            $display("FAIL outw_timeout_f%0d: got %0d beats want 8", f, got);
         end
      end
   endtask

   initial begin
      test_reset();
      test_dither_basic();
      test_bypass();
      test_stall();
      test_sync();
      test_reset_mid();
      test_outw2();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
